mc_datapath: RTL and testbench

//   Parametrised multi-cycle MIPS-subset datapath with an integrated control FSM.

---
 rtl/mc_datapath.sv | 154 +++++++++++++++
 tb/tb_mc_datapath.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset datapath: regfile, ALU, word-addressed data memory
// and the IDLE/DECODE/EXEC/MEM/WB control FSM that sequences one instruction at a time.
module mc_datapath #(
    parameter int DATA_W     = 32,
    parameter int NREGS      = 32,
    parameter int DMEM_DEPTH = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              INST_VALID,
    input  logic [31:0]       INST,
    output logic              INST_READY,
    output logic [DATA_W-1:0] regW,
    output logic              isZero,
    output logic [DATA_W-1:0] addr,
    output logic              done,
    output logic              err,
    input  logic [4:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);
    localparam int AW  = $clog2(DMEM_DEPTH);
    localparam int RIW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    state_t            r_state;
    logic [31:0]       r_inst;
    logic [DATA_W-1:0] r_a, r_b, r_imm, r_mdr;
    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];

    // Register indices above NREGS-1 fold back modulo NREGS.
    function automatic logic [RIW-1:0] ridx(input logic [4:0] r);
        int t;
        t = int'(r) % NREGS;
        return RIW'(t);
    endfunction

    logic [5:0]        w_op, w_funct;
    logic [RIW-1:0]    w_rs, w_rt, w_rd, w_dst, w_dbg;
    logic [DATA_W-1:0] w_rs_val, w_rt_val, w_alu, w_wdata;
    logic              w_supported;
    logic [AW-1:0]     w_midx;

    assign w_op      = r_inst[31:26];
    assign w_funct   = r_inst[5:0];
    assign w_rs      = ridx(r_inst[25:21]);
    assign w_rt      = ridx(r_inst[20:16]);
    assign w_rd      = ridx(r_inst[15:11]);
    assign w_dst     = (w_op == OP_R) ? w_rd : w_rt;
    assign w_dbg     = ridx(dbg_raddr);
    assign w_rs_val  = (w_rs == '0) ? '0 : r_regs[w_rs];
    assign w_rt_val  = (w_rt == '0) ? '0 : r_regs[w_rt];
    assign dbg_rdata = (w_dbg == '0) ? '0 : r_regs[w_dbg];
    assign w_wdata   = (w_op == OP_LW) ? r_mdr : addr;
    assign w_midx    = addr[AW+1:2];
    assign INST_READY = (r_state == S_IDLE);

    always_comb begin
        w_alu       = '0;
        w_supported = 1'b1;
        case (w_op)
            OP_R: begin
                case (w_funct)
                    6'h20:   w_alu = r_a + r_b;
                    6'h22:   w_alu = r_a - r_b;
                    6'h24:   w_alu = r_a & r_b;
                    6'h25:   w_alu = r_a | r_b;
                    6'h2A:   w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
                    default: w_supported = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: w_alu = r_a + r_imm;
            OP_BEQ:                w_alu = r_a - r_b;
            default:               w_supported = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_inst  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_imm   <= '0;
            r_mdr   <= '0;
            regW    <= '0;
            addr    <= '0;
            isZero  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                S_IDLE: if (INST_VALID) begin
                    r_inst  <= INST;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_a     <= w_rs_val;
                    r_b     <= w_rt_val;
                    r_imm   <= {{(DATA_W-16){r_inst[15]}}, r_inst[15:0]};
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    addr   <= w_alu;
                    isZero <= (w_alu == '0);
                    if (!w_supported) begin
                        done    <= 1'b1;
                        err     <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_op == OP_BEQ) begin
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_op == OP_LW || w_op == OP_SW) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (w_op == OP_LW) begin
                        r_mdr   <= r_dmem[w_midx];
                        r_state <= S_WB;
                    end else begin
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_WB: begin
                    // regW reflects the write even when $0 drops it.
                    regW <= w_wdata;
                    if (w_dst != '0) r_regs[w_dst] <= w_wdata;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Data memory is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (r_state == S_MEM && w_op == OP_SW) r_dmem[w_midx] <= r_b;
    end
endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: reset abort, ALU ops, memory wrap, beq,
// illegal funct and back-to-back issue with INST_VALID held high.
module tb_mc_datapath;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        INST_VALID = 1'b0;
    logic [31:0] INST = '0;
    logic        INST_READY;
    logic [31:0] regW, addr, dbg_rdata;
    logic        isZero, done, err;
    logic [4:0]  dbg_raddr = '0;

    int n_chk  = 0;
    int n_fail = 0;

    mc_datapath #(.DATA_W(32), .NREGS(32), .DMEM_DEPTH(64)) dut (
        .CLK(CLK), .RST(RST), .INST_VALID(INST_VALID), .INST(INST),
        .INST_READY(INST_READY), .regW(regW), .isZero(isZero), .addr(addr),
        .done(done), .err(err), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
        dbg_raddr = r;
        #1;
        chk(tag, dbg_rdata, exp);
    endtask

    // Issue one instruction, then count edges until done; checks latency and err.
    task automatic run(input string tag, input logic [31:0] inst, input int exp_lat, input logic exp_err);
        int lat;
        int w;
        w = 0;
        @(negedge CLK);
        while (!INST_READY && w < 20) begin @(negedge CLK); w++; end
        INST = inst;
        INST_VALID = 1'b1;
        @(posedge CLK);
        #1 INST_VALID = 1'b0;
        lat = 99;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) begin @(posedge CLK); #1; end
            else begin @(posedge CLK); #1; end
            if (done) begin lat = c; break; end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    endtask

    initial begin
        int acc, dn, idx;
        logic [31:0] prog [3];
        logic        rdy;
        logic        seen_done;

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_regW", regW, 0);
        chk("rst_addr", addr, 0);
        chk("rst_isZero", {31'b0, isZero}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_err", {31'b0, err}, 0);
        @(negedge CLK) RST = 1'b0;

        // T1: reset during EXEC of addi $1,$0,5
        INST = 32'h2001_0005;
        INST_VALID = 1'b1;
        @(posedge CLK); #1 INST_VALID = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        seen_done = 1'b0;
        repeat (2) begin @(posedge CLK); #1; seen_done |= done; end
        @(negedge CLK) RST = 1'b0;
        repeat (3) begin @(posedge CLK); #1; seen_done |= done; end
        chk("t1_ready", {31'b0, INST_READY}, 1);
        chk("t1_nodone", {31'b0, seen_done}, 0);
        chk_reg("t1_r1", 5'd1, 0);

        // T2
        run("addi2", 32'h2002_0007, 3, 1'b0);
        chk("addi2_regW", regW, 32'd7);
        run("addi3", 32'h2003_FFFD, 3, 1'b0);
        chk("addi3_regW", regW, 32'hFFFF_FFFD);
        run("add1", 32'h0043_0820, 3, 1'b0);
        chk("add1_regW", regW, 32'd4);
        chk_reg("add1_r1", 5'd1, 32'd4);

        // T3
        run("sub4", 32'h0062_2022, 3, 1'b0);
        chk("sub4_regW", regW, 32'hFFFF_FFF6);
        run("slt5", 32'h0062_282A, 3, 1'b0);
        chk("slt5_regW", regW, 32'd1);
        run("and6", 32'h0043_3024, 3, 1'b0);
        chk("and6_regW", regW, 32'd5);
        run("or9", 32'h0043_4825, 3, 1'b0);
        chk_reg("or9_r9", 5'd9, 32'hFFFF_FFFF);
        run("addi0", 32'h2000_0009, 3, 1'b0);
        chk("addi0_regW", regW, 32'd9);
        chk_reg("addi0_r0", 5'd0, 0);

        // T4
        run("sw", 32'hAC02_0008, 3, 1'b0);
        run("lw7", 32'h8C07_0008, 4, 1'b0);
        chk("lw7_regW", regW, 32'd7);
        chk("lw7_addr", addr, 32'd8);
        chk_reg("lw7_r7", 5'd7, 32'd7);
        run("lw8wrap", 32'h8C08_0108, 4, 1'b0);
        chk_reg("lw8_r8", 5'd8, 32'd7);

        // T5
        run("beq", 32'h1042_0010, 2, 1'b0);
        chk("beq_isZero", {31'b0, isZero}, 1);
        chk("beq_regW", regW, 32'd7);
        run("badfn", 32'h0043_503F, 2, 1'b1);
        chk_reg("badfn_r10", 5'd10, 0);
        chk_reg("badfn_r2", 5'd2, 32'd7);

        // T6: INST_VALID held, advance only on an accepting edge
        prog[0] = 32'h200C_0001;
        prog[1] = 32'h200D_0002;
        prog[2] = 32'h21AE_0001;
        acc = 0; dn = 0; idx = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            INST = prog[(idx < 3) ? idx : 2];
            INST_VALID = (idx < 3);
            rdy = INST_READY;
            @(posedge CLK);
            if (rdy && idx < 3) begin idx++; acc++; end
            #1;
            if (done) dn++;
        end
        INST_VALID = 1'b0;
        chk("t6_accepts", 32'(acc), 3);
        chk("t6_dones", 32'(dn), 3);
        chk_reg("t6_r12", 5'd12, 32'd1);
        chk_reg("t6_r13", 5'd13, 32'd2);
        chk_reg("t6_r14", 5'd14, 32'd3);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
